coin_motion_engine: RTL

COIN_MOTION_ENGINE -- requirements
Module: coin_motion_engine

---
 rtl/coin_motion_engine.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/coin_motion_engine.sv
// Coin motion engine: Q24.8 position/velocity integrator with wall reflection,
// friction decay and automatic stop, stepping once every TICK_DIV clock cycles.
module coin_motion_engine #(
    parameter int TICK_DIV   = 50000,
    parameter int X_MAX      = 239,
    parameter int Y_MAX      = 319,
    parameter int FRIC_SHIFT = 5,
    parameter int STOP_TH    = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] coin_x0,
    input  logic [31:0] coin_y0,
    input  logic [31:0] coin_vx0,
    input  logic [31:0] coin_vy0,
    output logic [31:0] coin_x,
    output logic [31:0] coin_y,
    output logic [31:0] counter,
    output logic        finish_flag,
    output logic        busy
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic signed [33:0] MX = 34'(X_MAX * 256);
    localparam logic signed [33:0] MY = 34'(Y_MAX * 256);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg;
    logic [TW-1:0]      tick_reg;
    logic signed [31:0] px_reg, py_reg, vx_reg, vy_reg;

    logic [31:0]        px_load, py_load;
    logic signed [33:0] px_sum, py_sum, px_next, py_next;
    logic signed [33:0] vx_ref, vy_ref, vx_fric, vy_fric;
    logic signed [31:0] vx_next, vy_next;
    logic               flip_x, flip_y, stop_now;

    // Clamp a signed integer start coordinate into [0, lim] and convert to Q24.8.
    function automatic logic [31:0] load_pos(input logic [31:0] c, input int lim);
        logic signed [31:0] s;
        s = signed'(c);
        if (s < 0)
            return 32'd0;
        else if (s > lim)
            return 32'(lim * 256);
        else
            return {c[23:0], 8'd0};
    endfunction

    // Mirror an out-of-range position back inside [0, m]; a velocity larger than
    // the whole field can overshoot the mirror, so the result is clamped as well.
    function automatic logic signed [33:0] reflect(input logic signed [33:0] s,
                                                   input logic signed [33:0] m);
        logic signed [33:0] r;
        if (s < 0)
            r = -s;
        else if (s > m)
            r = (m <<< 1) - s;
        else
            r = s;
        if (r < 0)
            r = '0;
        else if (r > m)
            r = m;
        return r;
    endfunction

    always_comb begin
        px_load  = load_pos(coin_x0, X_MAX);
        py_load  = load_pos(coin_y0, Y_MAX);
        px_sum   = {{2{px_reg[31]}}, px_reg} + {{2{vx_reg[31]}}, vx_reg};
        py_sum   = {{2{py_reg[31]}}, py_reg} + {{2{vy_reg[31]}}, vy_reg};
        flip_x   = (px_sum < 0) || (px_sum > MX);
        flip_y   = (py_sum < 0) || (py_sum > MY);
        px_next  = reflect(px_sum, MX);
        py_next  = reflect(py_sum, MY);
        vx_ref   = flip_x ? -{{2{vx_reg[31]}}, vx_reg} : {{2{vx_reg[31]}}, vx_reg};
        vy_ref   = flip_y ? -{{2{vy_reg[31]}}, vy_reg} : {{2{vy_reg[31]}}, vy_reg};
        vx_fric  = vx_ref - (vx_ref >>> FRIC_SHIFT);
        vy_fric  = vy_ref - (vy_ref >>> FRIC_SHIFT);
        vx_next  = 32'(vx_fric);
        vy_next  = 32'(vy_fric);
        stop_now = (vx_next > -STOP_TH) && (vx_next < STOP_TH) &&
                   (vy_next > -STOP_TH) && (vy_next < STOP_TH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            px_reg      <= '0;
            py_reg      <= '0;
            vx_reg      <= '0;
            vy_reg      <= '0;
            coin_x      <= '0;
            coin_y      <= '0;
            counter     <= '0;
            finish_flag <= 1'b0;
            busy        <= 1'b0;
        end else if (start) begin
            // A launch takes priority over any step due in the same cycle.
            state_reg   <= RUN;
            tick_reg    <= '0;
            px_reg      <= signed'(px_load);
            py_reg      <= signed'(py_load);
            vx_reg      <= signed'(coin_vx0);
            vy_reg      <= signed'(coin_vy0);
            coin_x      <= px_load >> 8;
            coin_y      <= py_load >> 8;
            counter     <= '0;
            finish_flag <= 1'b0;
            busy        <= 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_reg <= '0;
                        px_reg   <= 32'(px_next);
                        py_reg   <= 32'(py_next);
                        vx_reg   <= vx_next;
                        vy_reg   <= vy_next;
                        coin_x   <= 32'(px_next >>> 8);
                        coin_y   <= 32'(py_next >>> 8);
                        if (counter != 32'hFFFF_FFFF)
                            counter <= counter + 32'd1;
                        if (stop_now) begin
                            state_reg   <= DONE;
                            finish_flag <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end else begin
                        tick_reg <= tick_reg + TW'(1);
                    end
                end
                default: tick_reg <= '0;
            endcase
        end
    end

endmodule
